// File: rtl/syn_audio_pkg.sv
// syn_audio_pkg: shared PCM types plus audio cache controller state and read latency
package syn_audio_pkg;
  typedef enum logic {NORMAL, CAPTURE} acache_mode_t;
  typedef enum logic {BPS_16, BPS_32} bps_t;
  typedef struct packed {
    logic [31:0] lchnnl;
    logic [31:0] rchnnl;
  } pcm_data_t;
  typedef enum logic [1:0] {NRM, CAP_IDLE, CAP_FILL, CAP_DONE} acache_state_t;
  localparam int ACACHE_RD_LAT = 2;
  function automatic pcm_data_t pcm_fit(input pcm_data_t d, input bps_t b);
    pcm_data_t s;
    s.lchnnl = {{16{d.lchnnl[15]}}, d.lchnnl[15:0]};
    s.rchnnl = {{16{d.rchnnl[15]}}, d.rchnnl[15:0]};
    return b == BPS_16 ? s : d;
  endfunction
endpackage

// File: rtl/syn_acache_ram.sv
// syn_acache_ram: single-port synchronous PCM sample RAM with one-cycle read latency
module syn_acache_ram import syn_audio_pkg::*; #(
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk_ir,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pcm_data_t         wdata,
  output pcm_data_t         rdata
);
  pcm_data_t mem [MEM_DEPTH];
  always_ff @(posedge clk_ir) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/syn_acache_ctrl.sv
// syn_acache_ctrl: shares one sample RAM between codec ingress, DAC reads and host reads
// as a ring FIFO (NORMAL) or a one-shot snapshot buffer (CAPTURE).
module syn_acache_ctrl import syn_audio_pkg::*; #(
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  acache_mode_t      acache_mode_i,
  input  bps_t              bps_i,
  input  logic              cap_start_i,
  output logic              cap_done_o,
  input  logic              pcm_in_valid_i,
  input  pcm_data_t         pcm_in_i,
  output logic              pcm_in_ready_o,
  input  logic              dac_req_i,
  output logic              dac_valid_o,
  output pcm_data_t         dac_data_o,
  output logic              dac_underflow_o,
  input  logic              hst_rd_en_i,
  input  logic [ADDR_W-1:0] hst_addr_i,
  output logic              hst_rd_valid_o,
  output pcm_data_t         hst_rd_data_o,
  output logic [ADDR_W:0]   fill_o
);
  acache_state_t state, st, home;
  logic fresh, mode_chg, dac_hit, dac_uf, hst_hit, wr_en;
  logic [ADDR_W-1:0] wptr, rptr, ram_addr;
  logic [ADDR_W:0] count;
  logic dac_p, dac_s, uf_p, hst_p, hst_s;
  pcm_data_t ram_q;
  // Until the first edge after reset the state follows the mode pin, so the
  // reset state tracks acache_mode_i without an input-dependent async load.
  always_comb begin
    home = acache_mode_i == NORMAL ? NRM : CAP_IDLE;
    st = fresh ? home : state;
    mode_chg = (st == NRM) != (acache_mode_i == NORMAL);
    dac_hit = st == NRM && dac_req_i && count != '0;
    dac_uf = st == NRM && dac_req_i && count == '0;
    hst_hit = st == CAP_DONE && hst_rd_en_i;
    pcm_in_ready_o = st == NRM ? !count[ADDR_W] && !dac_req_i : 1'b1;
    wr_en = pcm_in_valid_i && (st == NRM ? pcm_in_ready_o : st == CAP_FILL);
    ram_addr = dac_hit ? rptr : hst_hit ? hst_addr_i : wptr;
    fill_o = st == NRM ? count : st == CAP_FILL ? {1'b0, wptr} :
             st == CAP_DONE ? (ADDR_W+1)'(MEM_DEPTH) : '0;
  end
  syn_acache_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk_ir(clk_ir),
    .we(wr_en),
    .addr(ram_addr),
    .wdata(pcm_fit(pcm_in_i, bps_i)),
    .rdata(ram_q)
  );
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      fresh <= 1'b1;
      state <= NRM;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      cap_done_o <= 1'b0;
    end else begin
      fresh <= 1'b0;
      cap_done_o <= 1'b0;
      state <= st;
      if (mode_chg) begin
        state <= home;
        wptr <= '0;
        rptr <= '0;
        count <= '0;
      end else if (st == NRM) begin
        if (wr_en) wptr <= wptr + 1'b1;
        if (dac_hit) rptr <= rptr + 1'b1;
        count <= count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(dac_hit);
      end else if (cap_start_i) begin
        state <= CAP_FILL;
        wptr <= '0;
      end else if (st == CAP_FILL && wr_en) begin
        wptr <= wptr + 1'b1;
        if (&wptr) begin
          state <= CAP_DONE;
          cap_done_o <= 1'b1;
        end
      end
    end
  end
  // Requests that miss the RAM still produce a valid beat carrying zero data.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      dac_p <= 1'b0;
      dac_s <= 1'b0;
      uf_p <= 1'b0;
      hst_p <= 1'b0;
      hst_s <= 1'b0;
      dac_valid_o <= 1'b0;
      dac_data_o <= '0;
      dac_underflow_o <= 1'b0;
      hst_rd_valid_o <= 1'b0;
      hst_rd_data_o <= '0;
    end else begin
      dac_p <= dac_req_i;
      dac_s <= dac_hit;
      uf_p <= dac_uf;
      hst_p <= hst_rd_en_i;
      hst_s <= hst_hit;
      dac_valid_o <= dac_p;
      dac_data_o <= dac_s ? ram_q : '0;
      dac_underflow_o <= uf_p;
      hst_rd_valid_o <= hst_p;
      hst_rd_data_o <= hst_s ? ram_q : '0;
    end
  end
endmodule

// File: tb/tb_syn_acache_ctrl.sv
// tb_syn_acache_ctrl: directed self-checking bench for the audio cache controller
module tb_syn_acache_ctrl;
  import syn_audio_pkg::*;
  localparam int AW = 7;
  logic clk_ir = 1'b0;
  logic rst_il, cap_start, cap_done, in_valid, in_ready, dac_req, dac_valid, dac_uf;
  logic hst_en, hst_valid;
  acache_mode_t mode;
  bps_t bps;
  pcm_data_t pcm_in, dac_data, hst_data;
  logic [AW-1:0] hst_addr;
  logic [AW:0] fill;
  int n_cmp = 0;
  int n_err = 0;

  syn_acache_ctrl #(.MEM_DEPTH(128), .ADDR_W(AW)) dut (
    .clk_ir(clk_ir),
    .rst_il(rst_il),
    .acache_mode_i(mode),
    .bps_i(bps),
    .cap_start_i(cap_start),
    .cap_done_o(cap_done),
    .pcm_in_valid_i(in_valid),
    .pcm_in_i(pcm_in),
    .pcm_in_ready_o(in_ready),
    .dac_req_i(dac_req),
    .dac_valid_o(dac_valid),
    .dac_data_o(dac_data),
    .dac_underflow_o(dac_uf),
    .hst_rd_en_i(hst_en),
    .hst_addr_i(hst_addr),
    .hst_rd_valid_o(hst_valid),
    .hst_rd_data_o(hst_data),
    .fill_o(fill)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic test_reset();
    rst_il = 1'b0; mode = NORMAL; bps = BPS_32; cap_start = 1'b0; in_valid = 1'b0;
    pcm_in = '0; dac_req = 1'b0; hst_en = 1'b0; hst_addr = '0;
    #12;
    n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL rst_dac_valid got %b want 0", dac_valid); end
    n_cmp++; if (hst_valid !== 1'b0) begin n_err++; $display("FAIL rst_hst_valid got %b want 0", hst_valid); end
    n_cmp++; if (dac_data !== 64'h0) begin n_err++; $display("FAIL rst_dac_data got %h want 0", dac_data); end
    n_cmp++; if (hst_data !== 64'h0) begin n_err++; $display("FAIL rst_hst_data got %h want 0", hst_data); end
    n_cmp++; if (fill !== 8'd0) begin n_err++; $display("FAIL rst_fill got %0d want 0", fill); end
    n_cmp++; if (cap_done !== 1'b0) begin n_err++; $display("FAIL rst_cap_done got %b want 0", cap_done); end
    n_cmp++; if (dac_uf !== 1'b0) begin n_err++; $display("FAIL rst_uf got %b want 0", dac_uf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_nrm got %b want 1", in_ready); end
    dac_req = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_nrm_dac got %b want 0", in_ready); end
    mode = CAPTURE; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_cap got %b want 1", in_ready); end
    mode = NORMAL; dac_req = 1'b0;
    @(negedge clk_ir); rst_il = 1'b1;
    tick();
  endtask

  task automatic test_fifo_order();
    logic [63:0] exp [3];
    exp[0] = 64'h00000001_00000002; exp[1] = 64'h00000003_00000004; exp[2] = 64'h00000005_00000006;
    bps = BPS_32;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; pcm_in = exp[i];
      tick();
      n_cmp++; if (fill !== 8'(i + 1)) begin n_err++; $display("FAIL fifo_fill_up[%0d] got %0d want %0d", i, fill, i + 1); end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      dac_req = (j < 3);
      tick();
      n_cmp++; if (dac_valid !== (j >= 1 && j <= 3)) begin n_err++; $display("FAIL fifo_valid[%0d] got %b", j, dac_valid); end
      if (j >= 1 && j <= 3) begin
        n_cmp++; if (dac_data !== exp[j-1]) begin n_err++; $display("FAIL fifo_data[%0d] got %h want %h", j, dac_data, exp[j-1]); end
      end
      n_cmp++; if (dac_uf !== 1'b0) begin n_err++; $display("FAIL fifo_uf[%0d] got %b want 0", j, dac_uf); end
      n_cmp++; if (fill !== 8'(j < 3 ? 2 - j : 0)) begin n_err++; $display("FAIL fifo_fill_dn[%0d] got %0d", j, fill); end
    end
    dac_req = 1'b0;
  endtask

  task automatic test_underflow();
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL uf_early_valid got %b want 0", dac_valid); end
    tick();
    n_cmp++; if (dac_valid !== 1'b1) begin n_err++; $display("FAIL uf_valid got %b want 1", dac_valid); end
    n_cmp++; if (dac_data !== 64'h0) begin n_err++; $display("FAIL uf_data got %h want 0", dac_data); end
    n_cmp++; if (dac_uf !== 1'b1) begin n_err++; $display("FAIL uf_pulse got %b want 1", dac_uf); end
    tick();
    n_cmp++; if (dac_valid !== 1'b0 || dac_uf !== 1'b0) begin n_err++; $display("FAIL uf_single got %b%b want 00", dac_valid, dac_uf); end
  endtask

  task automatic test_full_wrap();
    logic [63:0] x, e;
    x = 64'hAAAA5555_5555AAAA;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1; pcm_in = {32'h100 + 32'(i), 32'(i)};
      tick();
    end
    in_valid = 1'b0; #1;
    n_cmp++; if (fill !== 8'd128) begin n_err++; $display("FAIL full_fill got %0d want 128", fill); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", in_ready); end
    in_valid = 1'b1; pcm_in = x; dac_req = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready got %b want 0", in_ready); end
    tick();
    n_cmp++; if (fill !== 8'd127) begin n_err++; $display("FAIL prio_fill got %0d want 127", fill); end
    dac_req = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL prio_ready2 got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (dac_valid !== 1'b1 || dac_data !== 64'h00000100_00000000) begin n_err++; $display("FAIL prio_data got %b/%h want 1/0000010000000000", dac_valid, dac_data); end
    n_cmp++; if (fill !== 8'd128) begin n_err++; $display("FAIL prio_fill2 got %0d want 128", fill); end
    for (int j = 0; j < 130; j++) begin
      dac_req = (j < 128);
      tick();
      if (j >= 1 && j <= 128) begin
        e = (j == 128) ? x : {32'h100 + 32'(j), 32'(j)};
        n_cmp++; if (dac_valid !== 1'b1 || dac_data !== e) begin n_err++; $display("FAIL drain[%0d] got %b/%h want 1/%h", j, dac_valid, dac_data, e); end
      end
    end
    dac_req = 1'b0;
    n_cmp++; if (fill !== 8'd0 || dac_uf !== 1'b0) begin n_err++; $display("FAIL drain_end got fill %0d uf %b want 0 0", fill, dac_uf); end
  endtask

  task automatic test_capture();
    logic [AW-1:0] addrs [3];
    logic [63:0] hexp [3];
    addrs[0] = 7'd5; addrs[1] = 7'd127; addrs[2] = 7'd0;
    hexp[0] = 64'hFFFF8005_00000105; hexp[1] = 64'hFFFF807F_0000017F; hexp[2] = 64'hFFFF8000_00000100;
    mode = CAPTURE;
    tick();
    n_cmp++; if (fill !== 8'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL cap_idle got fill %0d ready %b want 0 1", fill, in_ready); end
    bps = BPS_16; cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1; pcm_in = {16'h1234, 16'h8000 + 16'(i), 16'h0000, 16'h0100 + 16'(i)};
      tick();
      n_cmp++; if (cap_done !== (i == 127)) begin n_err++; $display("FAIL cap_done[%0d] got %b", i, cap_done); end
      n_cmp++; if (fill !== 8'(i + 1)) begin n_err++; $display("FAIL cap_fill[%0d] got %0d want %0d", i, fill, i + 1); end
    end
    pcm_in = '1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (cap_done !== 1'b0 || fill !== 8'd128) begin n_err++; $display("FAIL cap_after got done %b fill %0d want 0 128", cap_done, fill); end
    for (int j = 0; j < 5; j++) begin
      hst_en = (j < 3);
      if (j < 3) hst_addr = addrs[j];
      tick();
      n_cmp++; if (hst_valid !== (j >= 1 && j <= 3)) begin n_err++; $display("FAIL hst_valid[%0d] got %b", j, hst_valid); end
      if (j >= 1 && j <= 3) begin
        n_cmp++; if (hst_data !== hexp[j-1]) begin n_err++; $display("FAIL hst_data[%0d] got %h want %h", j, hst_data, hexp[j-1]); end
      end
    end
    hst_en = 1'b0; dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    tick();
    n_cmp++; if (dac_valid !== 1'b1 || dac_data !== 64'h0 || dac_uf !== 1'b0) begin n_err++; $display("FAIL cap_dac got %b/%h/%b want 1/0/0", dac_valid, dac_data, dac_uf); end
  endtask

  task automatic test_mode_abort();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; pcm_in = {32'h0000_1000 + 32'(i), 32'h0};
      tick();
    end
    n_cmp++; if (fill !== 8'd40) begin n_err++; $display("FAIL abort_fill40 got %0d want 40", fill); end
    in_valid = 1'b0; mode = NORMAL;
    tick();
    n_cmp++; if (fill !== 8'd0) begin n_err++; $display("FAIL abort_fill got %0d want 0", fill); end
    dac_req = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready_dac got %b want 0", in_ready); end
    dac_req = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", in_ready); end
    hst_en = 1'b1; hst_addr = 7'd5;
    tick();
    hst_en = 1'b0;
    tick();
    n_cmp++; if (hst_valid !== 1'b1 || hst_data !== 64'h0) begin n_err++; $display("FAIL abort_hst got %b/%h want 1/0", hst_valid, hst_data); end
  endtask

  task automatic test_reset_inflight();
    bps = BPS_32; in_valid = 1'b1; pcm_in = 64'h000000AA_000000BB;
    tick();
    in_valid = 1'b0; dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    #2 rst_il = 1'b0;
    #1;
    n_cmp++; if (dac_valid !== 1'b0 || dac_data !== 64'h0) begin n_err++; $display("FAIL rstf_dac got %b/%h want 0/0", dac_valid, dac_data); end
    n_cmp++; if (fill !== 8'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstf_fill got %0d ready %b want 0 1", fill, in_ready); end
    n_cmp++; if (hst_valid !== 1'b0 || cap_done !== 1'b0 || dac_uf !== 1'b0) begin n_err++; $display("FAIL rstf_misc got %b%b%b want 000", hst_valid, cap_done, dac_uf); end
    tick();
    @(negedge clk_ir); rst_il = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL rstf_post[%0d] got %b want 0", j, dac_valid); end
    end
    n_cmp++; if (fill !== 8'd0) begin n_err++; $display("FAIL rstf_fill_end got %0d want 0", fill); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_underflow();
    test_full_wrap();
    test_capture();
    test_mode_abort();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/syn_acache_ctrl.md
# syn_acache_ctrl

Audio cache controller for the Synesthesia audio path. It owns one single-port PCM sample RAM and shares it between three requesters: codec ingress writes, DAC-side reads and host reads. In NORMAL mode the RAM is a ring FIFO between codec and DAC. In CAPTURE mode it takes a one-shot snapshot of the incoming PCM stream, which the host then reads back by address.

## Interface
- MEM_DEPTH, 128: sample entries (power of 2, ≥4)
- ADDR_W, 7: log2(MEM_DEPTH)
- clk_ir  in  1  system clock
- rst_il  in  1  reset; asynchronous, active-low
- acache_mode_i  in  1  acache_mode_t (NORMAL/CAPTURE)
- bps_i  in  1  bps_t (BPS_16/BPS_32)
- cap_start_i  in  1  capture start pulse
- cap_done_o  out  1  one-cycle pulse when snapshot is full
- pcm_in_valid_i  in  1  ingress sample valid
- pcm_in_i  in  64  pcm_data_t ingress sample
- pcm_in_ready_o  out  1  ingress accept (combinational)
- dac_req_i  in  1  DAC sample request
- dac_valid_o  out  1  DAC response valid
- dac_data_o  out  64  pcm_data_t DAC sample
- dac_underflow_o  out  1  pulse: request served while empty
- hst_rd_en_i  in  1  host read request
- hst_addr_i  in  ADDR_W  host read address
- hst_rd_valid_o  out  1  host read response valid
- hst_rd_data_o  out  64  pcm_data_t host data
- fill_o  out  ADDR_W+1  current occupancy

## Operation
- FSM states: NRM, CAP_IDLE, CAP_FILL, CAP_DONE.
- Reset state: NRM if acache_mode_i=NORMAL, else CAP_IDLE.
- Mode change: any acache_mode_i change → NRM or CAP_IDLE next cycle. Pointers and fill_o clear. In-flight responses still complete.
- NRM:
  - Ring FIFO with wptr, rptr and count.
  - Port priority: DAC read > ingress write. Host reads are not serviced.
  - pcm_in_ready_o = (count<MEM_DEPTH) && !dac_req_i.
  - Write: at wptr when valid&&ready; wptr+1 mod MEM_DEPTH.
  - DAC request with count>0: read at rptr, then rptr+1.
  - DAC request with count=0: no RAM access; response data 0 with dac_underflow_o pulse aligned to dac_valid_o.
  - count changes by +1 on write and −1 on pop (never both in one cycle).
- CAP_IDLE: pcm_in_ready_o=1 and samples are dropped; DAC requests return 0.
  - cap_start_i moves to CAP_FILL and sets wptr=0.
- CAP_FILL:
  - pcm_in_ready_o=1; every valid sample is written at wptr, wptr+1.
  - DAC requests return 0.
  - The write of address MEM_DEPTH−1 moves to CAP_DONE and pulses cap_done_o the next cycle.
  - cap_start_i in this state restarts at wptr=0.
- CAP_DONE: ingress dropped (ready=1); DAC returns 0.
  - Host read at hst_addr_i is serviced.
  - cap_start_i moves to CAP_FILL.
- Host read outside CAP_DONE: hst_rd_valid_o is still returned at normal latency, with data 0.
- Width rule: BPS_16 stores each channel as sign-extended bits [15:0]; BPS_32 stores the channel as is. bps_i is sampled at write time.
- fill_o:
  - NRM: count.
  - CAP_FILL: wptr.
  - CAP_DONE: MEM_DEPTH.
  - CAP_IDLE: 0.

## Timing
- Requests are sampled at edge N and the RAM address is driven in cycle N. RAM data returns in N+1. Output registers are loaded, so dac_valid_o and hst_rd_valid_o assert in cycle N+2 for exactly one cycle.
- Fixed latency 2 for both read ports. Back-to-back requests every cycle are allowed (throughput 1).
- Write occupancy visible on fill_o at N+1.
- Reset values: all valid/pulse outputs 0, data outputs 0, fill_o 0, pcm_in_ready_o per reset state with count=0.
  - NRM: ready=!dac_req_i.
  - Capture states: ready=1.
- Reset mid-operation: in-flight responses are discarded and no valid is issued after reset release.
- Simultaneous cap_start_i and mode change: mode change wins.

## Structure
- Add to syn_audio_pkg: acache_state_t enum (NRM, CAP_IDLE, CAP_FILL, CAP_DONE) and ACACHE_RD_LAT=2.
- pcm_data_t, bps_t and acache_mode_t come from syn_audio_pkg.
- Sub-module syn_acache_ram: single-port synchronous RAM, MEM_DEPTH×64, 1-cycle read latency, write-first irrelevant (no same-cycle read/write).

## Test plan
- NRM, BPS_32: write 0x1_2, 0x3_4, 0x5_6, then 3 DAC requests → same order at latency 2, fill_o 3→0, no underflow.
- NRM: fill 128 → pcm_in_ready_o=0. DAC request while valid pending → ready low that cycle, DAC served, write accepted next cycle, wptr wraps to 0.
- NRM empty DAC request → dac_valid_o at N+2, data 0, dac_underflow_o=1.
- CAPTURE, BPS_16: cap_start_i, then 128 samples with lchnnl[15:0]=0x8000+i → cap_done_o one pulse. Host read addr 5 returns lchnnl=0xFFFF_8005 at latency 2. Extra ingress samples are ignored.
- CAP_FILL after 40 samples: toggle acache_mode_i to NORMAL → state NRM, fill_o=0, ready follows NRM rule. Host read → data 0.
- rst_il asserted with DAC read in flight → no dac_valid_o after release; all outputs at reset values.
